// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the multiplexed 7-segment display scanner.
// Segment vectors are [0:6] = a..g, active-low.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal nibbles render blank.
module seg7_bcd_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed BCD display scanner with tear-free frame-boundary updates and inter-digit blanking.
// Optional macro HEX_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
//
//   state | meaning
//   IDLE  | display dark, waiting for en; pending data copied to display immediately
//   GAP   | all digits dark for GAP_CYCLES between digits
//   SCAN  | digit idx lit for SCAN_DIV cycles; last digit's terminal count is the frame boundary
module hex_display_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       data_in,
  output logic                          ready,
  output logic [0:6]                    seg,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SCAN_LOAD = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] display;
  logic                    pending_valid;

  logic [3:0] nib;
  logic [0:6] dec_seg;
  logic [0:6] lit_seg;
  logic       lz_blank;
  logic       frame_boundary;

  always_comb begin
    nib = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) nib = display[4*k +: 4];
    end
  end

  seg7_bcd_decode u_decode (
    .bcd (nib),
    .seg (dec_seg)
  );

`ifdef HEX_LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_blank = 1'b0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) lz_blank = ((display >> (4*k)) == '0);
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign lit_seg        = lz_blank ? SEG_BLANK : dec_seg;
  assign frame_boundary = en && (state == SCAN) && (cnt == '0) && (idx == LAST_IDX);
  assign ready          = ~pending_valid;
  assign digit_idx      = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      display       <= '0;
      seg           <= SEG_BLANK;
      digit_sel     <= '1;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // A full pending buffer blocks new loads, so update and accept never collide.
      if (pending_valid && ((state == IDLE) || frame_boundary)) begin
        display       <= pending;
        pending_valid <= 1'b0;
      end else if (load && !pending_valid) begin
        pending       <= data_in;
        pending_valid <= 1'b1;
      end

      if (!en) begin
        state     <= IDLE;
        cnt       <= '0;
        idx       <= '0;
        seg       <= SEG_BLANK;
        digit_sel <= '1;
      end else begin
        case (state)
          IDLE: begin
            state     <= GAP;
            cnt       <= GAP_LOAD;
            idx       <= '0;
            seg       <= SEG_BLANK;
            digit_sel <= '1;
          end
          GAP: begin
            if (cnt == '0) begin
              state     <= SCAN;
              cnt       <= SCAN_LOAD;
              seg       <= lit_seg;
              digit_sel <= ~(NUM_DIGITS'(1) << idx);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SCAN: begin
            if (cnt == '0) begin
              state     <= GAP;
              cnt       <= GAP_LOAD;
              seg       <= SEG_BLANK;
              digit_sel <= '1;
              if (idx == LAST_IDX) begin
                idx        <= '0;
                frame_done <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            seg       <= SEG_BLANK;
            digit_sel <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench: directed sequences and a vector table, with a frame-timing reference
// model checking every cycle, plus a randomized phase.
module tb_hex_display_scanner;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int GC    = 1;
  localparam int SLOT  = GC + SD;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        ready;
  logic [0:6]  seg;
  logic [3:0]  digit_sel;
  logic [1:0]  digit_idx;
  logic        frame_done;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .GAP_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .ready      (ready),
    .seg        (seg),
    .digit_sel  (digit_sel),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [6:0] ref_dec(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: position in the frame is just elapsed time since enable.
  bit          mv = 0;
  bit          running = 0;
  int          t = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  bit          m_pv = 0;

  always @(posedge clk) begin
    bit bnd;
    if (rst) begin
      mv = 1; running = 0; t = 0; m_disp = 16'h0; m_pv = 0;
    end else begin
      bnd = running && en && ((t % FRAME) == FRAME - 1);
      if (m_pv && (!running || bnd)) begin
        m_disp = m_pend; m_pv = 0;
      end else if (load && !m_pv) begin
        m_pend = data_in; m_pv = 1;
      end
      if (!en) begin
        running = 0; t = 0;
      end else if (!running) begin
        running = 1; t = 0;
      end else begin
        t++;
      end
    end
  end

  always @(negedge clk) begin
    logic [6:0] e_seg;
    logic [3:0] e_sel;
    logic [1:0] e_idx;
    logic       e_fd;
    int         o, d;
    if (mv) begin
      e_seg = 7'b1111111; e_sel = 4'b1111; e_idx = 2'd0; e_fd = 1'b0;
      if (running) begin
        o = t % SLOT;
        d = (t / SLOT) % ND;
        e_idx = 2'(d);
        e_fd  = (t > 0) && ((t % FRAME) == 0);
        if (o >= GC) begin
          e_sel = ~(4'b0001 << d);
          e_seg = ref_dec(4'((m_disp >> (4*d)) & 16'hF));
`ifdef HEX_LEADING_ZERO_BLANK_EN
          if (d > 0 && (m_disp >> (4*d)) == 16'h0) e_seg = 7'b1111111;
`endif
        end
      end
      chk("model", {17'h0, seg, digit_sel, digit_idx, frame_done, ready},
          {17'h0, e_seg, e_sel, e_idx, e_fd, ~m_pv});
    end
  end

  task automatic wait_sel(input string nm, input logic [3:0] s);
    for (int i = 0; i < 200 && digit_sel !== s; i++) tick();
    chk(nm, digit_sel, s);
  endtask

  task automatic wait_fd(input string nm);
    for (int i = 0; i < 200 && frame_done !== 1'b1; i++) tick();
    chk(nm, frame_done, 1'b1);
  endtask

  task automatic show(input logic [15:0] v);
    en = 1'b0; tick();
    load = 1'b1; data_in = v; tick();
    load = 1'b0; tick();
    en = 1'b1;
  endtask

  typedef struct {
    logic [15:0] data;
    int          dig;
    logic [6:0]  exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n;
    logic [6:0] e_lz;
    logic [3:0] s;

    tbl[0] = '{16'h12A4, 1, 7'b1111111};
    tbl[1] = '{16'h12A4, 0, 7'b1001100};
    tbl[2] = '{16'h12A4, 2, 7'b0010010};
    tbl[3] = '{16'h12A4, 3, 7'b1001111};
    tbl[4] = '{16'h5678, 0, 7'b0000000};
    tbl[5] = '{16'h5678, 1, 7'b0001111};
    tbl[6] = '{16'h5678, 2, 7'b0100000};
    tbl[7] = '{16'h5678, 3, 7'b0100100};
    tbl[8] = '{16'hFED9, 0, 7'b0000100};
    tbl[9] = '{16'hFED9, 2, 7'b1111111};

`ifdef HEX_LEADING_ZERO_BLANK_EN
    e_lz = 7'b1111111;
`else
    e_lz = 7'b0000001;
`endif

    // Reset
    rst = 1'b1; tick(); tick();
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_sel", digit_sel, 4'b1111);
    chk("rst_ready", ready, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_idx", digit_idx, 2'd0);

    // Load in IDLE, then scan
    rst = 1'b0;
    load = 1'b1; data_in = 16'h1234; tick();
    load = 1'b0; tick();
    chk("idle_ready", ready, 1'b1);
    en = 1'b1;
    wait_sel("d0_lit", 4'b1110);
    chk("d0_seg", seg, 7'b1001100);
    n = 0;
    while (digit_sel === 4'b1110 && n < 50) begin n++; tick(); end
    chk("d0_len", n, SD);
    chk("gap_sel", digit_sel, 4'b1111);
    chk("gap_seg", seg, 7'b1111111);
    tick();
    chk("d1_sel", digit_sel, 4'b1101);
    chk("d1_seg", seg, 7'b0000110);
    wait_fd("fd_first");
    n = 0;
    do begin tick(); n++; end while (frame_done !== 1'b1 && n < 100);
    chk("fd_period", n, FRAME);

    // Mid-frame load, second load ignored
    tick(); tick(); tick();
    load = 1'b1; data_in = 16'h0987; tick();
    load = 1'b0;
    chk("mid_ready0", ready, 1'b0);
    load = 1'b1; data_in = 16'h5555; tick();
    load = 1'b0;
    chk("mid_ready1", ready, 1'b0);
    wait_fd("fd_update");
    chk("post_ready", ready, 1'b1);
    wait_sel("n_d0", 4'b1110); chk("n_d0_seg", seg, 7'b0001111);
    wait_sel("n_d1", 4'b1101); chk("n_d1_seg", seg, 7'b0000000);
    wait_sel("n_d2", 4'b1011); chk("n_d2_seg", seg, 7'b0000100);
    wait_sel("n_d3", 4'b0111); chk("n_d3_seg", seg, e_lz);

    // Vector table
    foreach (tbl[i]) begin
      show(tbl[i].data);
      s = ~(4'b0001 << tbl[i].dig);
      wait_sel("tbl_sel", s);
      chk("tbl_seg", seg, tbl[i].exp);
    end

    // en drop mid-SCAN
    wait_sel("en_d2", 4'b1011);
    en = 1'b0; tick();
    chk("en0_sel", digit_sel, 4'b1111);
    chk("en0_seg", seg, 7'b1111111);
    chk("en0_idx", digit_idx, 2'd0);
    en = 1'b1; tick();
    chk("re_gap", digit_sel, 4'b1111);
    tick();
    chk("re_d0", digit_sel, 4'b1110);

    // Reset mid-SCAN with pending data
    load = 1'b1; data_in = 16'h4321; tick();
    load = 1'b0;
    chk("pend_ready", ready, 1'b0);
    wait_sel("rs_d1", 4'b1101);
    tick();
    rst = 1'b1; tick();
    chk("mr_seg", seg, 7'b1111111);
    chk("mr_sel", digit_sel, 4'b1111);
    chk("mr_ready", ready, 1'b1);
    chk("mr_fd", frame_done, 1'b0);
    chk("mr_idx", digit_idx, 2'd0);
    rst = 1'b0;
    wait_sel("z_d0", 4'b1110); chk("z_d0_seg", seg, 7'b0000001);
    wait_sel("z_d1", 4'b1101); chk("z_d1_seg", seg, e_lz);

    // Leading-zero case
    show(16'h0050);
    wait_sel("lz_d0", 4'b1110); chk("lz_d0_seg", seg, 7'b0000001);
    wait_sel("lz_d1", 4'b1101); chk("lz_d1_seg", seg, 7'b0100100);
    wait_sel("lz_d2", 4'b1011); chk("lz_d2_seg", seg, e_lz);
    wait_sel("lz_d3", 4'b0111); chk("lz_d3_seg", seg, e_lz);

    // Randomized phase, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 499) == 0);
      en      = ($urandom_range(0, 63) != 0);
      load    = ($urandom_range(0, 7) == 0);
      data_in = 16'($urandom);
      tick();
    end
    rst = 1'b0; en = 1'b0; load = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
